generic_sram_byte_en_initiator: RTL and testbench
=================================================

# generic_sram_byte_en_initiator

Synthesizable initiator for the generic SRAM byte-enable interface. It converts a valid/ready request stream (reads and byte-masked writes) into single-cycle SRAM port accesses and returns read data in order on a valid/ready response stream. A credit counter makes sure every issued read has a guaranteed response-buffer slot. It sits between a core-side load/store or DMA engine and any `generic_sram_byte_en` target: an SRAM macro, the target BFM, or a cluster memory port.

## Interface
Parameters:
- `ADR_WIDTH`, 20, word address width.
- `DAT_WIDTH`, 32, data width; must be a multiple of 8.
- `RD_LATENCY`, 1, cycles from the SRAM sampling an address to valid `sram_read_data`; legal range 1..4.
- `RSP_DEPTH`, 4, response FIFO entries; power of two, at least 2.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when this and `req_valid` are both high ("fire").
- `req_we` in 1: 1 = write, 0 = read.
- `req_adr` in `ADR_WIDTH`: word address.
- `req_sel` in `DAT_WIDTH/8`: write byte enables.
- `req_dat_w` in `DAT_WIDTH`: write data.
- `rsp_valid` out 1: read data valid.
- `rsp_ready` in 1: consumer accepts read data.
- `rsp_dat_r` out `DAT_WIDTH`: read data.
- `sram_addr` out `ADR_WIDTH`: SRAM address.
- `sram_write_en` out 1: SRAM write strobe.
- `sram_byte_en` out `DAT_WIDTH/8`: SRAM byte enables.
- `sram_write_data` out `DAT_WIDTH`: SRAM write data.
- `sram_read_data` in `DAT_WIDTH`: SRAM read data.

## Operation
Credits:
- `credits` register, width `$clog2(RSP_DEPTH)+1`, resets to `RSP_DEPTH`.
- `req_ready` = `credits != 0`. It does not depend on `req_we`, so writes also stall when credits are 0.
- A read fire decrements `credits`; a response handshake (`rsp_valid & rsp_ready`) increments it.
- When both happen in the same cycle, `credits` is unchanged.
- `credits` never exceeds `RSP_DEPTH` and never underflows.

Issue stage (registered):
- On any fire, the next cycle drives `sram_addr` = `req_adr`.
- Write fire: `sram_write_en` = 1, `sram_byte_en` = `req_sel`, `sram_write_data` = `req_dat_w`.
- Read fire: `sram_write_en` = 0, `sram_byte_en` = 0.
- No fire: `sram_write_en` = 0 and `sram_byte_en` = 0; `sram_addr` and `sram_write_data` hold their last values.

Read tracking:
- A shift register of `RD_LATENCY+1` valid bits tags each issued read.
- When a tag reaches the final stage, `sram_read_data` is pushed into the response FIFO that cycle.
- The push never meets a full FIFO, because a credit was reserved at fire.

Response FIFO:
- In-order, `RSP_DEPTH` entries.
- `rsp_valid` = FIFO not empty; `rsp_dat_r` = head entry.
- Head pops on `rsp_valid & rsp_ready`.
- Pointers wrap modulo `RSP_DEPTH`.
- Push and pop in the same cycle are both honoured, including when the FIFO is empty (no bypass) or full.

Writes produce no response.

Reset (`reset_n` low, any time, including mid-transaction):
- Outputs: `req_ready` = 1, `rsp_valid` = 0, `rsp_dat_r` = 0, `sram_addr` = 0, `sram_write_en` = 0, `sram_byte_en` = 0, `sram_write_data` = 0.
- State: `credits` = `RSP_DEPTH`; tag pipeline and FIFO pointers cleared.
- In-flight reads are discarded; no stale response appears after reset releases.

## Timing
- Read fire in cycle T: SRAM port driven in T+1, data sampled in T+1+`RD_LATENCY`, `rsp_valid` high in T+2+`RD_LATENCY`. With the default `RD_LATENCY` = 1 this is 3 cycles.
- Write fire in cycle T: `sram_write_en` high in T+1 only.
- Throughput: one request per cycle while `credits` > 0. Sustained back-to-back reads need `RSP_DEPTH` ≥ `RD_LATENCY`+2 with `rsp_ready` held high.
- `req_ready` is a function of registered state only, so there is no combinational path from `req_*` or `rsp_ready` to `req_ready`.
- `rsp_valid` and `rsp_dat_r` are FIFO-registered outputs.

## Structure
- Shared package `generic_sram_byte_en_pkg`: the `RD_LATENCY` legal-range constants and an `sram_req_t` struct (`we`, `adr`, `sel`, `dat_w`) parameterised by the default widths.
- One natural sub-module, `generic_sram_byte_en_rsp_fifo`: synchronous FIFO with async active-low reset, `DEPTH` and `WIDTH` parameters, and push/pop/empty/full/head ports.
- Credit counter, issue registers and tag pipeline live in the top module.

## Test plan
- Write 0xDEADBEEF to 0x00010 with `sel` = 0xF, then read 0x00010 → one `rsp_dat_r` = 0xDEADBEEF, 3 cycles after the read fire.
- Partial write 0x000000AA to 0x00020 with `sel` = 0x1 over prior 0x11223344, then read → `rsp_dat_r` = 0x112233AA; `sram_byte_en` = 0x1 for exactly one cycle.
- 16 back-to-back reads of addresses 0..15 (memory[i] = i) with `rsp_ready` = 1 and `RSP_DEPTH` = 4 → `req_ready` stays high, responses 0..15 in order, one per cycle.
- `rsp_ready` = 0 with reads offered continuously → exactly 4 reads accepted, then `req_ready` = 0 and `sram_write_en` = 0. Raising `rsp_ready` for one cycle → exactly one more read accepted.
- Reset asserted 1 cycle after 2 read fires → after release, `rsp_valid` stays 0 for 10 cycles and `credits` = 4.
- `RD_LATENCY` = 2 build: read fire → `rsp_valid` 4 cycles later with correct data; a simultaneous read fire and response pop leaves `credits` unchanged.

Source files
------------

// File: rtl/generic_sram_byte_en_pkg.sv
// ---------------------------------------------------------------------------
// generic_sram_byte_en_pkg
// Shared definitions for the generic SRAM byte-enable initiator:
//   - legal range of the SRAM read latency
//   - default address/data widths
//   - sram_req_t: one request (we, adr, sel, dat_w) at the default widths
//   - apply_byte_enables: merges write data into a word under a byte mask
// No ports (package).
// ---------------------------------------------------------------------------
package generic_sram_byte_en_pkg;

    localparam int RD_LATENCY_MIN    = 1;
    localparam int RD_LATENCY_MAX    = 4;
    localparam int DEFAULT_ADR_WIDTH = 20;
    localparam int DEFAULT_DAT_WIDTH = 32;
    localparam int DEFAULT_SEL_WIDTH = DEFAULT_DAT_WIDTH / 8;

    typedef struct packed {
        logic                         we;
        logic [DEFAULT_ADR_WIDTH-1:0] adr;
        logic [DEFAULT_SEL_WIDTH-1:0] sel;
        logic [DEFAULT_DAT_WIDTH-1:0] dat_w;
    } sram_req_t;

    // Byte-masked merge: byte b of the result comes from new_word when
    // sel[b] is set, otherwise it keeps the old byte.
    function automatic logic [DEFAULT_DAT_WIDTH-1:0] apply_byte_enables(
        input logic [DEFAULT_DAT_WIDTH-1:0] old_word,
        input logic [DEFAULT_DAT_WIDTH-1:0] new_word,
        input logic [DEFAULT_SEL_WIDTH-1:0] sel
    );
        logic [DEFAULT_DAT_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < DEFAULT_SEL_WIDTH; b++) begin
            if (sel[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/generic_sram_byte_en_initiator_if.sv
// ---------------------------------------------------------------------------
// generic_sram_byte_en_initiator_if
// Bundles the three buses the initiator touches:
//   - request stream  : req_valid/req_ready/req_we/req_adr/req_sel/req_dat_w
//   - response stream : rsp_valid/rsp_ready/rsp_dat_r
//   - SRAM port       : sram_addr/sram_write_en/sram_byte_en/
//                       sram_write_data/sram_read_data
// Modports:
//   master : the initiator itself (bus master of the SRAM port)
//   slave  : everything around it (request source, response sink, SRAM)
// ---------------------------------------------------------------------------
interface generic_sram_byte_en_initiator_if
    import generic_sram_byte_en_pkg::*;
#(
    parameter int ADR_WIDTH = DEFAULT_ADR_WIDTH,
    parameter int DAT_WIDTH = DEFAULT_DAT_WIDTH
);
    localparam int SEL_WIDTH = DAT_WIDTH / 8;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [ADR_WIDTH-1:0] req_adr;
    logic [SEL_WIDTH-1:0] req_sel;
    logic [DAT_WIDTH-1:0] req_dat_w;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DAT_WIDTH-1:0] rsp_dat_r;

    logic [ADR_WIDTH-1:0] sram_addr;
    logic                 sram_write_en;
    logic [SEL_WIDTH-1:0] sram_byte_en;
    logic [DAT_WIDTH-1:0] sram_write_data;
    logic [DAT_WIDTH-1:0] sram_read_data;

    modport master (
        input  req_valid, req_we, req_adr, req_sel, req_dat_w,
        output req_ready,
        output rsp_valid, rsp_dat_r,
        input  rsp_ready,
        output sram_addr, sram_write_en, sram_byte_en, sram_write_data,
        input  sram_read_data
    );

    modport slave (
        output req_valid, req_we, req_adr, req_sel, req_dat_w,
        input  req_ready,
        input  rsp_valid, rsp_dat_r,
        output rsp_ready,
        input  sram_addr, sram_write_en, sram_byte_en, sram_write_data,
        output sram_read_data
    );

endinterface

// File: rtl/generic_sram_byte_en_rsp_fifo.sv
// ---------------------------------------------------------------------------
// generic_sram_byte_en_rsp_fifo
// In-order synchronous FIFO holding read data until the consumer takes it.
// Ports:
//   clock, reset_n   : rising-edge clock, asynchronous active-low reset
//   push, push_data  : write one entry
//   pop              : drop the head entry
//   empty, full      : occupancy flags
//   head             : current head entry (registered storage, no bypass)
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width).
// ---------------------------------------------------------------------------
module generic_sram_byte_en_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head
);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_WIDTH:0] wr_ptr;
    logic [PTR_WIDTH:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                   (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

    // A push into a full FIFO is honoured only when the head leaves in the
    // same cycle, which frees exactly the slot being written.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head = mem[rd_ptr[PTR_WIDTH-1:0]];

    // Storage and pointers; storage is cleared so the head reads zero
    // after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[PTR_WIDTH-1:0]] <= push_data;
                wr_ptr                     <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/generic_sram_byte_en_initiator.sv
// ---------------------------------------------------------------------------
// generic_sram_byte_en_initiator
// Turns a valid/ready request stream (reads and byte-masked writes) into
// single-cycle SRAM accesses and returns read data, in order, on a
// valid/ready response stream.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : master modport carrying the request stream, response stream
//             and SRAM port
// Parameters: ADR_WIDTH, DAT_WIDTH (multiple of 8), RD_LATENCY (1..4),
//             RSP_DEPTH (power of two, >= 2).
// ---------------------------------------------------------------------------
module generic_sram_byte_en_initiator
    import generic_sram_byte_en_pkg::*;
#(
    parameter int ADR_WIDTH  = DEFAULT_ADR_WIDTH,
    parameter int DAT_WIDTH  = DEFAULT_DAT_WIDTH,
    parameter int RD_LATENCY = RD_LATENCY_MIN,
    parameter int RSP_DEPTH  = 4
) (
    input logic                              clock,
    input logic                              reset_n,
    generic_sram_byte_en_initiator_if.master bus
);
    localparam int SEL_WIDTH = DAT_WIDTH / 8;
    localparam int CRD_WIDTH = $clog2(RSP_DEPTH) + 1;

    logic [CRD_WIDTH-1:0]  credits;
    logic                  req_fire;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  rsp_fire;

    logic [ADR_WIDTH-1:0]  addr_q;
    logic                  write_en_q;
    logic [SEL_WIDTH-1:0]  byte_en_q;
    logic [DAT_WIDTH-1:0]  write_data_q;

    logic [RD_LATENCY:0]   tag_q;
    logic                  fifo_push;
    logic                  fifo_empty;
    logic                  fifo_full;

    // req_ready looks only at the credit register, so neither the request
    // fields nor rsp_ready reach it combinationally.
    assign bus.req_ready = (credits != '0);
    assign req_fire      = bus.req_valid & bus.req_ready;
    assign rd_fire       = req_fire & ~bus.req_we;
    assign wr_fire       = req_fire & bus.req_we;
    assign rsp_fire      = bus.rsp_valid & bus.rsp_ready;

    // One credit per free response slot: a read reserves its slot when it
    // is accepted and gives it back when its data leaves the FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            credits <= CRD_WIDTH'(RSP_DEPTH);
        end else if (rd_fire && !rsp_fire) begin
            credits <= credits - CRD_WIDTH'(1);
        end else if (!rd_fire && rsp_fire) begin
            credits <= credits + CRD_WIDTH'(1);
        end
    end

    // Issue stage: strobes are single-cycle, address and write data hold
    // their last values between accesses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            write_en_q   <= 1'b0;
            byte_en_q    <= '0;
            write_data_q <= '0;
        end else begin
            write_en_q <= wr_fire;
            byte_en_q  <= wr_fire ? bus.req_sel : '0;
            if (req_fire) begin
                addr_q <= bus.req_adr;
            end
            if (wr_fire) begin
                write_data_q <= bus.req_dat_w;
            end
        end
    end

    assign bus.sram_addr       = addr_q;
    assign bus.sram_write_en   = write_en_q;
    assign bus.sram_byte_en    = byte_en_q;
    assign bus.sram_write_data = write_data_q;

    // Read tags: stage 0 lines up with the cycle the SRAM sees the address,
    // stage RD_LATENCY with the cycle its read data is valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[RD_LATENCY-1:0], rd_fire};
        end
    end

    assign fifo_push = tag_q[RD_LATENCY];

    generic_sram_byte_en_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DAT_WIDTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (bus.sram_read_data),
        .pop       (rsp_fire),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head      (bus.rsp_dat_r)
    );

    assign bus.rsp_valid = ~fifo_empty;

    // The credit scheme guarantees a free slot for every tagged read.
    push_never_overflows: assert property (
        @(posedge clock) disable iff (!reset_n)
        !(fifo_push && fifo_full && !rsp_fire)
    );

endmodule

// File: tb/tb_generic_sram_byte_en_initiator.sv
// ---------------------------------------------------------------------------
// tb_generic_sram_byte_en_initiator
// Two initiators (RD_LATENCY 1 and 2, RSP_DEPTH 4) each talking to a small
// behavioural SRAM. The latency-1 instance is followed cycle by cycle by a
// transaction-level model; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_generic_sram_byte_en_initiator;
    import generic_sram_byte_en_pkg::*;

    localparam int DEPTH = 4;
    localparam int LAT1  = 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } timed_word_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    generic_sram_byte_en_initiator_if #(.ADR_WIDTH(20), .DAT_WIDTH(32)) bus1 ();
    generic_sram_byte_en_initiator_if #(.ADR_WIDTH(20), .DAT_WIDTH(32)) bus2 ();

    generic_sram_byte_en_initiator #(
        .ADR_WIDTH(20), .DAT_WIDTH(32), .RD_LATENCY(LAT1), .RSP_DEPTH(DEPTH)
    ) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    generic_sram_byte_en_initiator #(
        .ADR_WIDTH(20), .DAT_WIDTH(32), .RD_LATENCY(2), .RSP_DEPTH(DEPTH)
    ) dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 32) ? 32'h11223344 : 32'(i);
    endfunction

    // Behavioural SRAMs: contents reload while reset is held.
    logic [31:0] sram1 [64];
    logic [31:0] sram2 [64];
    logic [31:0] sram2_stage;

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) begin
                sram1[i] <= init_word(i);
                sram2[i] <= init_word(i);
            end
        end else begin
            if (bus1.sram_write_en)
                sram1[bus1.sram_addr[5:0]] <= apply_byte_enables(
                    sram1[bus1.sram_addr[5:0]], bus1.sram_write_data, bus1.sram_byte_en);
            if (bus2.sram_write_en)
                sram2[bus2.sram_addr[5:0]] <= apply_byte_enables(
                    sram2[bus2.sram_addr[5:0]], bus2.sram_write_data, bus2.sram_byte_en);
        end
        bus1.sram_read_data <= sram1[bus1.sram_addr[5:0]];
        sram2_stage         <= sram2[bus2.sram_addr[5:0]];
        bus2.sram_read_data <= sram2_stage;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Model of the latency-1 instance: reference memory, queue of expected
    // responses stamped with the cycle they become visible.
    logic [31:0] ref_mem [64];
    timed_word_t exp_q[$];
    timed_word_t rsp_log[$];

    initial begin : compare_proc
        int          outstanding;
        logic        prev_we;
        logic [3:0]  prev_sel;
        logic [19:0] last_addr;
        logic [31:0] last_wdata;
        logic        exp_ready;
        logic        exp_valid;
        logic        fire;
        timed_word_t entry;
        outstanding = 0;
        prev_we     = 1'b0;
        prev_sel    = '0;
        last_addr   = '0;
        last_wdata  = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                check_output("rst_req_ready", 32'(bus1.req_ready), 32'd1);
                check_output("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
                check_output("rst_rsp_dat_r", bus1.rsp_dat_r, 32'd0);
                check_output("rst_sram_addr", 32'(bus1.sram_addr), 32'd0);
                check_output("rst_sram_we", 32'(bus1.sram_write_en), 32'd0);
                check_output("rst_sram_be", 32'(bus1.sram_byte_en), 32'd0);
                check_output("rst_sram_wdata", bus1.sram_write_data, 32'd0);
                check_output("rst2_req_ready", 32'(bus2.req_ready), 32'd1);
                check_output("rst2_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
                exp_q.delete();
                outstanding = 0;
                prev_we     = 1'b0;
                prev_sel    = '0;
                last_addr   = '0;
                last_wdata  = '0;
                for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
            end else begin
                exp_ready = (outstanding < DEPTH);
                exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
                check_output("m_req_ready", 32'(bus1.req_ready), 32'(exp_ready));
                check_output("m_sram_we", 32'(bus1.sram_write_en), 32'(prev_we));
                check_output("m_sram_be", 32'(bus1.sram_byte_en), 32'(prev_sel));
                check_output("m_sram_addr", 32'(bus1.sram_addr), 32'(last_addr));
                check_output("m_sram_wdata", bus1.sram_write_data, last_wdata);
                check_output("m_rsp_valid", 32'(bus1.rsp_valid), 32'(exp_valid));
                if (exp_valid)
                    check_output("m_rsp_dat_r", bus1.rsp_dat_r, exp_q[0].data);

                fire     = bus1.req_valid && exp_ready;
                prev_we  = fire && bus1.req_we;
                prev_sel = prev_we ? bus1.req_sel : 4'h0;
                if (fire) last_addr = bus1.req_adr;
                if (prev_we) begin
                    last_wdata = bus1.req_dat_w;
                    ref_mem[bus1.req_adr[5:0]] = apply_byte_enables(
                        ref_mem[bus1.req_adr[5:0]], bus1.req_dat_w, bus1.req_sel);
                end
                if (fire && !bus1.req_we) begin
                    entry.data = ref_mem[bus1.req_adr[5:0]];
                    entry.cyc  = cyc + 2 + LAT1;
                    exp_q.push_back(entry);
                    outstanding++;
                end
                if (exp_valid && bus1.rsp_ready) begin
                    void'(exp_q.pop_front());
                    outstanding--;
                end
            end
        end
    end

    // Log of response handshakes on the latency-1 instance.
    initial begin : log_proc
        timed_word_t e;
        forever begin
            @(negedge clock);
            if (reset_n && bus1.rsp_valid && bus1.rsp_ready) begin
                e.data = bus1.rsp_dat_r;
                e.cyc  = cyc;
                rsp_log.push_back(e);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cycle(input int n);
        do @(negedge clock); while (cyc < n);
    endtask

    // Offers one request on bus1 and returns the cycle in which it fired.
    task automatic apply_stimulus(input sram_req_t r, output int fire_cyc);
        bit fired;
        fired    = 1'b0;
        fire_cyc = -1;
        bus1.req_valid = 1'b1;
        bus1.req_we    = r.we;
        bus1.req_adr   = r.adr;
        bus1.req_sel   = r.sel;
        bus1.req_dat_w = r.dat_w;
        for (int i = 0; i < 50 && !fired; i++) begin
            @(negedge clock);
            if (bus1.req_ready) begin
                fired    = 1'b1;
                fire_cyc = cyc;
            end
        end
        if (fired) sync();
        bus1.req_valid = 1'b0;
        check_output("req_accepted", 32'(fired), 32'd1);
    endtask

    initial begin : main_proc
        sram_req_t r;
        int f;
        int f0;
        int accepted;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_adr = '0;
        bus1.req_sel = '0; bus1.req_dat_w = '0; bus1.rsp_ready = 1'b1;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_adr = '0;
        bus2.req_sel = '0; bus2.req_dat_w = '0; bus2.rsp_ready = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) sync();
        reset_n = 1'b1;
        sync();

        // Full write then read back, three cycles after the read fire.
        r = '{we: 1'b1, adr: 20'h00010, sel: 4'hF, dat_w: 32'hDEADBEEF};
        apply_stimulus(r, f);
        r = '{we: 1'b0, adr: 20'h00010, sel: 4'h0, dat_w: 32'h0};
        apply_stimulus(r, f);
        wait_cycle(f + 2);
        check_output("t1_valid_early", 32'(bus1.rsp_valid), 32'd0);
        wait_cycle(f + 3);
        check_output("t1_valid", 32'(bus1.rsp_valid), 32'd1);
        check_output("t1_data", bus1.rsp_dat_r, 32'hDEADBEEF);
        sync();

        // Single-byte write over 0x11223344.
        r = '{we: 1'b1, adr: 20'h00020, sel: 4'h1, dat_w: 32'h000000AA};
        apply_stimulus(r, f);
        wait_cycle(f + 1);
        check_output("t2_be_on", 32'(bus1.sram_byte_en), 32'h1);
        check_output("t2_we_on", 32'(bus1.sram_write_en), 32'd1);
        wait_cycle(f + 2);
        check_output("t2_be_off", 32'(bus1.sram_byte_en), 32'h0);
        sync();
        r = '{we: 1'b0, adr: 20'h00020, sel: 4'h0, dat_w: 32'h0};
        apply_stimulus(r, f);
        wait_cycle(f + 3);
        check_output("t2_valid", 32'(bus1.rsp_valid), 32'd1);
        check_output("t2_data", bus1.rsp_dat_r, 32'h112233AA);
        sync();

        // 16 back-to-back reads of 0..15.
        rsp_log.delete();
        f0 = -1;
        for (int i = 0; i < 16; i++) begin
            bus1.req_valid = 1'b1;
            bus1.req_we    = 1'b0;
            bus1.req_adr   = 20'(i);
            @(negedge clock);
            check_output("t3_ready", 32'(bus1.req_ready), 32'd1);
            if (i == 0) f0 = cyc;
            sync();
        end
        bus1.req_valid = 1'b0;
        repeat (8) sync();
        check_output("t3_count", 32'(rsp_log.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < rsp_log.size()) begin
                check_output("t3_data", rsp_log[i].data, 32'(i));
                check_output("t3_cycle", 32'(rsp_log[i].cyc), 32'(f0 + 3 + i));
            end
        end

        // Credit exhaustion with the consumer stalled.
        bus1.rsp_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 8; k++) begin
            bus1.req_valid = 1'b1;
            bus1.req_we    = 1'b0;
            bus1.req_adr   = 20'(40 + k);
            @(negedge clock);
            if (bus1.req_ready) accepted++;
            sync();
        end
        check_output("t4_accepted", 32'(accepted), 32'd4);
        @(negedge clock);
        check_output("t4_ready_low", 32'(bus1.req_ready), 32'd0);
        check_output("t4_we_low", 32'(bus1.sram_write_en), 32'd0);
        sync();
        bus1.rsp_ready = 1'b1;
        accepted = 0;
        @(negedge clock);
        if (bus1.req_ready) accepted++;
        sync();
        bus1.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus1.req_adr = 20'(50 + k);
            @(negedge clock);
            if (bus1.req_ready) accepted++;
            sync();
        end
        check_output("t4_one_more", 32'(accepted), 32'd1);
        bus1.req_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        repeat (10) sync();

        // Reset one cycle after two read fires.
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b0;
        bus1.req_adr   = 20'd1;
        @(negedge clock);
        check_output("t5_fire1", 32'(bus1.req_ready), 32'd1);
        sync();
        bus1.req_adr = 20'd2;
        @(negedge clock);
        check_output("t5_fire2", 32'(bus1.req_ready), 32'd1);
        sync();
        reset_n        = 1'b0;
        bus1.req_valid = 1'b0;
        sync();
        sync();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check_output("t5_no_stale", 32'(bus1.rsp_valid), 32'd0);
            if (k == 0 || k == 9)
                check_output("t5_credits", 32'(dut1.credits), 32'd4);
        end
        sync();

        // Latency-2 instance: four-cycle read latency.
        bus2.rsp_ready = 1'b1;
        bus2.req_valid = 1'b1;
        bus2.req_we    = 1'b0;
        bus2.req_adr   = 20'd3;
        @(negedge clock);
        check_output("t6_ready", 32'(bus2.req_ready), 32'd1);
        f = cyc;
        sync();
        bus2.req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_cycle(f + k);
            check_output("t6_valid_early", 32'(bus2.rsp_valid), 32'd0);
        end
        wait_cycle(f + 4);
        check_output("t6_valid", 32'(bus2.rsp_valid), 32'd1);
        check_output("t6_data", bus2.rsp_dat_r, 32'd3);
        sync();

        // Simultaneous read fire and response pop leaves credits alone.
        bus2.rsp_ready = 1'b0;
        bus2.req_valid = 1'b1;
        bus2.req_adr   = 20'd7;
        @(negedge clock);
        f = cyc;
        sync();
        bus2.req_valid = 1'b0;
        wait_cycle(f + 4);
        check_output("t6_held_valid", 32'(bus2.rsp_valid), 32'd1);
        check_output("t6_credits_before", 32'(dut2.credits), 32'd3);
        sync();
        bus2.rsp_ready = 1'b1;
        bus2.req_valid = 1'b1;
        bus2.req_adr   = 20'd9;
        @(negedge clock);
        f = cyc;
        check_output("t6_both_ready", 32'(bus2.req_ready), 32'd1);
        check_output("t6_both_valid", 32'(bus2.rsp_valid), 32'd1);
        check_output("t6_pop_data", bus2.rsp_dat_r, 32'd7);
        sync();
        bus2.req_valid = 1'b0;
        @(negedge clock);
        check_output("t6_credits_after", 32'(dut2.credits), 32'd3);
        wait_cycle(f + 4);
        check_output("t6_second_valid", 32'(bus2.rsp_valid), 32'd1);
        check_output("t6_second_data", bus2.rsp_dat_r, 32'd9);
        repeat (4) sync();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
